// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared types for the control-signal pipeline. Holds the
//               per-stage control subsets, their bubble values and the
//               forwarding select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // Controls consumed in EX
  typedef struct packed {
    logic       alusrc;
    logic       regdst;
    logic [1:0] aluop;
  } ex_ctrl_t;

  // Controls consumed in MEM (memtoreg travels on to WB as well)
  typedef struct packed {
    logic memwrite;
    logic memtoreg;
    logic branch;
  } mem_ctrl_t;

  // Controls consumed in WB
  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  // Operand source select for the ALU inputs
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam ex_ctrl_t  EX_BUBBLE  = '0;
  localparam mem_ctrl_t MEM_BUBBLE = '0;
  localparam wb_ctrl_t  WB_BUBBLE  = '0;

endpackage
`default_nettype wire

// File: rtl/ctrl_hazard.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_hazard
// Description : Combinational hazard detection for ctrl_pipe. Produces the
//               hazard stall request and the EX operand forwarding selects.
//               Build option CTRL_PIPE_FWD_EN: when defined, MEM/WB results
//               are forwarded and only load-use stalls; when undefined, no
//               forwarding and any RAW on an EX/MEM writer stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_hazard
  import ctrl_pkg::*;
#(
  parameter int REGW = 3
) (
  input  logic            id_valid_i,
  input  logic [REGW-1:0] id_rs_i,
  input  logic [REGW-1:0] id_rt_i,
  input  logic            ex_valid_i,
  input  logic            ex_memtoreg_i,
  input  logic            ex_regwrite_i,
  input  logic [REGW-1:0] ex_wreg_i,
  input  logic [REGW-1:0] ex_rs_i,
  input  logic [REGW-1:0] ex_rt_i,
  input  logic            mem_valid_i,
  input  logic            mem_regwrite_i,
  input  logic [REGW-1:0] mem_wreg_i,
  input  logic            wb_valid_i,
  input  logic            wb_regwrite_i,
  input  logic [REGW-1:0] wb_wreg_i,
  output logic            haz_stall_o,
  output fwd_sel_t        fwd_a_o,
  output fwd_sel_t        fwd_b_o
);

  // A stage is a result producer only if it is real, writes, and targets
  // something other than r0 (r0 is hardwired and never a source).
  logic ex_writes_w;
  logic mem_writes_w;
  logic ex_hits_id_w;
  logic lu_w;

  assign ex_writes_w  = ex_valid_i & ex_regwrite_i & (ex_wreg_i != '0);
  assign mem_writes_w = mem_valid_i & mem_regwrite_i & (mem_wreg_i != '0);
  assign ex_hits_id_w = ex_writes_w & ((ex_wreg_i == id_rs_i) | (ex_wreg_i == id_rt_i));
  assign lu_w         = id_valid_i & ex_memtoreg_i & ex_hits_id_w;

`ifdef CTRL_PIPE_FWD_EN
  logic wb_writes_w;
  assign wb_writes_w = wb_valid_i & wb_regwrite_i & (wb_wreg_i != '0);

  // Only a load result is too late to forward into the next instruction
  assign haz_stall_o = lu_w;

  // MEM holds the younger result, so it wins over WB
  always_comb begin
    fwd_a_o = FWD_RF;
    fwd_b_o = FWD_RF;
    if (mem_writes_w && (mem_wreg_i == ex_rs_i))     fwd_a_o = FWD_MEM;
    else if (wb_writes_w && (wb_wreg_i == ex_rs_i))  fwd_a_o = FWD_WB;
    if (mem_writes_w && (mem_wreg_i == ex_rt_i))     fwd_b_o = FWD_MEM;
    else if (wb_writes_w && (wb_wreg_i == ex_rt_i))  fwd_b_o = FWD_WB;
  end
`else
  logic mem_hits_id_w;
  logic unused_w;

  assign mem_hits_id_w = mem_writes_w & ((mem_wreg_i == id_rs_i) | (mem_wreg_i == id_rt_i));

  // Without forwarding the reader waits until its producer reaches WB,
  // where the regfile write lands in the first half of the cycle.
  assign haz_stall_o = lu_w | (id_valid_i & (ex_hits_id_w | mem_hits_id_w));
  assign fwd_a_o     = FWD_RF;
  assign fwd_b_o     = FWD_RF;
  assign unused_w    = ^{ex_rs_i, ex_rt_i, wb_valid_i, wb_regwrite_i, wb_wreg_i};
`endif

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe
// Description : Control-signal pipeline downstream of maindec. Carries the
//               decoded control word through ID/EX, EX/MEM and MEM/WB with
//               destination tracking, and resolves branch/jump redirect,
//               bubble insertion and hazard stalls.
//               Build option CTRL_PIPE_FWD_EN enables operand forwarding
//               (see ctrl_hazard).
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REGW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid_i,
  input  logic            memtoreg_i,
  input  logic            memwrite_i,
  input  logic            branch_i,
  input  logic            alusrc_i,
  input  logic            regdst_i,
  input  logic            regwrite_i,
  input  logic            jump_i,
  input  logic [1:0]      aluop_i,
  input  logic [REGW-1:0] id_rs_i,
  input  logic [REGW-1:0] id_rt_i,
  input  logic [REGW-1:0] id_rd_i,
  input  logic            ex_zero_i,
  input  logic            stall_i,
  output logic            ex_alusrc_o,
  output logic            ex_regdst_o,
  output logic [1:0]      ex_aluop_o,
  output logic            mem_memwrite_o,
  output logic            mem_memtoreg_o,
  output logic            wb_regwrite_o,
  output logic            wb_memtoreg_o,
  output logic [REGW-1:0] wb_wreg_o,
  output logic            pcsrc_o,
  output logic            jump_o,
  output logic            hold_o,
  output logic [1:0]      fwd_a_o,
  output logic [1:0]      fwd_b_o
);

  // ---------------- stage registers ----------------
  logic            ex_valid_q,  ex_valid_d;
  ex_ctrl_t        ex_ex_q,     ex_ex_d;
  mem_ctrl_t       ex_mem_q,    ex_mem_d;
  wb_ctrl_t        ex_wb_q,     ex_wb_d;
  logic            ex_jump_q,   ex_jump_d;
  logic [REGW-1:0] ex_rs_q,     ex_rs_d;
  logic [REGW-1:0] ex_rt_q,     ex_rt_d;
  logic [REGW-1:0] ex_rd_q,     ex_rd_d;

  logic            mem_valid_q, mem_valid_d;
  mem_ctrl_t       mem_mem_q,   mem_mem_d;
  wb_ctrl_t        mem_wb_q,    mem_wb_d;
  logic [REGW-1:0] mem_wreg_q,  mem_wreg_d;
  logic            mem_zero_q,  mem_zero_d;

  logic            wb_valid_q,  wb_valid_d;
  wb_ctrl_t        wb_wb_q,     wb_wb_d;
  logic [REGW-1:0] wb_wreg_q,   wb_wreg_d;

  // ---------------- combinational helpers ----------------
  ex_ctrl_t        id_ex_w;
  mem_ctrl_t       id_mem_w;
  wb_ctrl_t        id_wb_w;
  logic [REGW-1:0] ex_wreg_w;
  logic            pcsrc_w;
  logic            jump_w;
  logic            haz_stall_w;
  logic            hold_req_w;
  fwd_sel_t        fwd_a_w;
  fwd_sel_t        fwd_b_w;

  // Invalid ID slots enter EX as clean bubbles so nothing can leak later
  assign id_ex_w  = id_valid_i ? ex_ctrl_t'{alusrc: alusrc_i, regdst: regdst_i, aluop: aluop_i}
                               : EX_BUBBLE;
  assign id_mem_w = id_valid_i ? mem_ctrl_t'{memwrite: memwrite_i, memtoreg: memtoreg_i,
                                             branch: branch_i}
                               : MEM_BUBBLE;
  assign id_wb_w  = id_valid_i ? wb_ctrl_t'{regwrite: regwrite_i, memtoreg: memtoreg_i}
                               : WB_BUBBLE;

  assign ex_wreg_w  = ex_ex_q.regdst ? ex_rd_q : ex_rt_q;
  assign pcsrc_w    = mem_valid_q & mem_mem_q.branch & mem_zero_q;
  assign jump_w     = ex_valid_q & ex_jump_q;
  assign hold_req_w = haz_stall_w | stall_i;

  ctrl_hazard #(
    .REGW (REGW)
  ) u_hazard (
    .id_valid_i     (id_valid_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .ex_valid_i     (ex_valid_q),
    .ex_memtoreg_i  (ex_mem_q.memtoreg),
    .ex_regwrite_i  (ex_wb_q.regwrite),
    .ex_wreg_i      (ex_wreg_w),
    .ex_rs_i        (ex_rs_q),
    .ex_rt_i        (ex_rt_q),
    .mem_valid_i    (mem_valid_q),
    .mem_regwrite_i (mem_wb_q.regwrite),
    .mem_wreg_i     (mem_wreg_q),
    .wb_valid_i     (wb_valid_q),
    .wb_regwrite_i  (wb_wb_q.regwrite),
    .wb_wreg_i      (wb_wreg_q),
    .haz_stall_o    (haz_stall_w),
    .fwd_a_o        (fwd_a_w),
    .fwd_b_o        (fwd_b_w)
  );

  // Next-state priority: branch flush, then jump, then stall, else advance
  always_comb begin
    wb_valid_d  = mem_valid_q;
    wb_wb_d     = mem_wb_q;
    wb_wreg_d   = mem_wreg_q;

    mem_valid_d = ex_valid_q;
    mem_mem_d   = ex_mem_q;
    mem_wb_d    = ex_wb_q;
    mem_wreg_d  = ex_wreg_w;
    mem_zero_d  = ex_valid_q & ex_zero_i;

    ex_valid_d  = id_valid_i;
    ex_ex_d     = id_ex_w;
    ex_mem_d    = id_mem_w;
    ex_wb_d     = id_wb_w;
    ex_jump_d   = id_valid_i & jump_i;
    ex_rs_d     = id_valid_i ? id_rs_i : '0;
    ex_rt_d     = id_valid_i ? id_rt_i : '0;
    ex_rd_d     = id_valid_i ? id_rd_i : '0;

    // A taken branch also kills the instruction currently in EX
    if (pcsrc_w) begin
      mem_valid_d = 1'b0;
      mem_mem_d   = MEM_BUBBLE;
      mem_wb_d    = WB_BUBBLE;
      mem_wreg_d  = '0;
      mem_zero_d  = 1'b0;
    end

    if (pcsrc_w || jump_w || hold_req_w) begin
      ex_valid_d = 1'b0;
      ex_ex_d    = EX_BUBBLE;
      ex_mem_d   = MEM_BUBBLE;
      ex_wb_d    = WB_BUBBLE;
      ex_jump_d  = 1'b0;
      ex_rs_d    = '0;
      ex_rt_d    = '0;
      ex_rd_d    = '0;
    end
  end

  // Stage registers; reset drops every in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_ex_q     <= EX_BUBBLE;
      ex_mem_q    <= MEM_BUBBLE;
      ex_wb_q     <= WB_BUBBLE;
      ex_jump_q   <= 1'b0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_rd_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_mem_q   <= MEM_BUBBLE;
      mem_wb_q    <= WB_BUBBLE;
      mem_wreg_q  <= '0;
      mem_zero_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_wb_q     <= WB_BUBBLE;
      wb_wreg_q   <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ex_q     <= ex_ex_d;
      ex_mem_q    <= ex_mem_d;
      ex_wb_q     <= ex_wb_d;
      ex_jump_q   <= ex_jump_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_rd_q     <= ex_rd_d;
      mem_valid_q <= mem_valid_d;
      mem_mem_q   <= mem_mem_d;
      mem_wb_q    <= mem_wb_d;
      mem_wreg_q  <= mem_wreg_d;
      mem_zero_q  <= mem_zero_d;
      wb_valid_q  <= wb_valid_d;
      wb_wb_q     <= wb_wb_d;
      wb_wreg_q   <= wb_wreg_d;
    end
  end

  // ---------------- outputs ----------------
  assign ex_alusrc_o    = ex_ex_q.alusrc;
  assign ex_regdst_o    = ex_ex_q.regdst;
  assign ex_aluop_o     = ex_ex_q.aluop;
  assign mem_memwrite_o = mem_mem_q.memwrite;
  assign mem_memtoreg_o = mem_mem_q.memtoreg;
  assign wb_regwrite_o  = wb_wb_q.regwrite;
  assign wb_memtoreg_o  = wb_wb_q.memtoreg;
  assign wb_wreg_o      = wb_wreg_q;
  assign pcsrc_o        = pcsrc_w;
  assign jump_o         = jump_w;
  // A redirect already discards the ID instruction, so it overrides a hold;
  // stall_i is masked during reset so every output reads 0 there.
  assign hold_o         = rst_n & hold_req_w & ~pcsrc_w & ~jump_w;
  assign fwd_a_o        = fwd_a_w;
  assign fwd_b_o        = fwd_b_w;

endmodule
`default_nettype wire
